// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the cpu datapath, the memory-port arbiter and physical memory.
// The slave modport is the arbiter's view. The master modport is the view of the
// surrounding system, which drives the requests and the physical memory responses.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int MASK_W = DATA_W / 8;

    // Instruction-fetch side (port a)
    logic              read_a;
    logic [ADDR_W-1:0] address_a;
    logic              resp_a;
    logic [DATA_W-1:0] rdata_a;

    // Data-access side (port b)
    logic              read_b;
    logic              write;
    logic [MASK_W-1:0] wmask;
    logic [ADDR_W-1:0] address_b;
    logic [DATA_W-1:0] wdata;
    logic              resp_b;
    logic [DATA_W-1:0] rdata_b;

    // Physical memory side
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [DATA_W-1:0] pmem_wdata;
    logic [MASK_W-1:0] pmem_wmask;
    logic [DATA_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  read_a, address_a, read_b, write, wmask, address_b, wdata,
        input  pmem_rdata, pmem_resp,
        output resp_a, rdata_a, resp_b, rdata_b,
        output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_wmask
    );

    modport master (
        output read_a, address_a, read_b, write, wmask, address_b, wdata,
        output pmem_rdata, pmem_resp,
        input  resp_a, rdata_a, resp_b, rdata_b,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_wmask
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one physical memory port between instruction fetch (port a) and data
// access (port b). One transaction is in flight at a time; the granted request is
// latched so the physical strobes stay stable whatever the requesters do meanwhile.
// The data side wins ties, but after STARVE_LIMIT data grants taken while fetch was
// waiting, fetch is forced through on the next decision.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_port_arbiter_if.slave     bus
);
    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERV_I = 2'd1,
        SERV_D = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;
    logic              op_write_q, op_write_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;

    logic i_pend_s;
    logic d_pend_s;
    logic grant_i_s;
    logic grant_d_s;
    logic resp_a_s;
    logic resp_b_s;

    // Grant decision: data first, fetch when alone or when it has waited too long
    always_comb begin
        i_pend_s  = bus.read_a;
        d_pend_s  = bus.read_b | bus.write;
        grant_i_s = i_pend_s & (~d_pend_s | (starve_cnt_q == CNT_LIMIT));
        grant_d_s = d_pend_s & ~grant_i_s;
    end

    // Next state, request latching and starvation counting
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        op_write_d   = op_write_q;
        starve_cnt_d = starve_cnt_q;
        case (state_q)
            IDLE: begin
                if (grant_i_s) begin
                    state_d      = SERV_I;
                    addr_d       = bus.address_a;
                    wdata_d      = {DATA_W{1'b0}};
                    wmask_d      = {MASK_W{1'b0}};
                    op_write_d   = 1'b0;
                    starve_cnt_d = {CNT_W{1'b0}};
                end else if (grant_d_s) begin
                    state_d    = SERV_D;
                    addr_d     = bus.address_b;
                    wdata_d    = bus.wdata;
                    wmask_d    = bus.wmask;
                    // A simultaneous read_b and write is treated as a write
                    op_write_d = bus.write;
                    if (i_pend_s && (starve_cnt_q != CNT_LIMIT)) begin
                        starve_cnt_d = starve_cnt_q + CNT_ONE;
                    end else begin
                        starve_cnt_d = starve_cnt_q;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SERV_I, SERV_D: begin
                if (bus.pmem_resp) begin
                    state_d = IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched-request registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= {ADDR_W{1'b0}};
            wdata_q      <= {DATA_W{1'b0}};
            wmask_q      <= {MASK_W{1'b0}};
            op_write_q   <= 1'b0;
            starve_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            op_write_q   <= op_write_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Completion is a same-cycle pass-through of pmem_resp to the served side only
    always_comb begin
        resp_a_s = (state_q == SERV_I) & bus.pmem_resp;
        resp_b_s = (state_q == SERV_D) & bus.pmem_resp;
    end

    assign bus.resp_a       = resp_a_s;
    assign bus.resp_b       = resp_b_s;
    assign bus.rdata_a      = resp_a_s ? bus.pmem_rdata : {DATA_W{1'b0}};
    assign bus.rdata_b      = resp_b_s ? bus.pmem_rdata : {DATA_W{1'b0}};
    assign bus.pmem_read    = (state_q != IDLE) & ~op_write_q;
    assign bus.pmem_write   = (state_q == SERV_D) & op_write_q;
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wdata_q;
    assign bus.pmem_wmask   = wmask_q;
endmodule
